gemm_tile_engine: RTL
=====================

GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

Interface
REQ-001 SHALL have parameter InDataWidth, default 8, input element width.
REQ-002 SHALL have parameter OutDataWidth, default 32, accumulator/output element width.
REQ-003 SHALL have parameter AddrWidth, default 16, SRAM tile-address width.
REQ-004 SHALL have parameter SizeAddrWidth, default 8, tile-count width.
REQ-005 SHALL have parameters TileM, TileN, TileK, each default 4, defining the PE grid (TileM x TileN) and dot-product depth (TileK).
REQ-006 SHALL have ports:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: reset; asynchronous, active-low.
- start_i, in, 1: start pulse.
- signed_i, in, 1: operand mode, 1 = signed, 0 = unsigned.
- m_tiles_i / k_tiles_i / n_tiles_i, in, SizeAddrWidth: matrix sizes in tiles.
- sram_a_addr_o / sram_b_addr_o, out, AddrWidth: read tile addresses.
- sram_rd_o, out, 1: read strobe for A and B.
- sram_a_rdata_i, in, InDataWidth*TileM*TileK: A tile.
- sram_b_rdata_i, in, InDataWidth*TileK*TileN: B tile.
- sram_c_addr_o, out, AddrWidth: write tile address.
- sram_c_wdata_o, out, OutDataWidth*TileM*TileN: C tile.
- sram_c_we_o, out, 1: write request.
- sram_c_ready_i, in, 1: write accepted.
- busy_o, out, 1: operation active.
- done_o, out, 1: completion pulse.

Function
REQ-007 SHALL latch the three sizes and signed_i on start_i in IDLE; start_i outside IDLE is ignored.
REQ-008 SHALL implement FSM IDLE -> RUN -> FLUSH -> WRITE -> (RUN | DONE) -> IDLE.
REQ-009 SHALL, on start_i with any size zero, go IDLE -> DONE, issue no reads or writes, and pulse done_o one cycle later.
REQ-010 SHALL loop with m outermost, then n, then k innermost.
REQ-011 In RUN, SHALL assert sram_rd_o and issue one (m,k,n) read per cycle, with a_addr = m*k_tiles + k and b_addr = k*n_tiles + n (truncated to AddrWidth).
REQ-012 Read data SHALL be valid exactly one cycle after its address.
REQ-013 SHALL go to FLUSH after issuing k = k_tiles-1; FLUSH lasts 1 cycle to absorb the final data.
REQ-014 Each PE SHALL load (not add) the product sum for k = 0 and accumulate for k > 0.
REQ-015 Packing SHALL be: A(i,k) at bit (i*TileK+k)*InDataWidth; B(k,j) at bit (j*TileK+k)*InDataWidth (column-major); C(i,j) at bit (i*TileN+j)*OutDataWidth.
REQ-016 Arithmetic: products are 2*InDataWidth wide and sign- or zero-extended per the latched mode; sums wrap modulo 2^OutDataWidth.
REQ-017 In WRITE, SHALL hold sram_c_we_o = 1 with sram_c_addr_o = m*n_tiles + n and stable wdata until sram_c_ready_i = 1; the write completes on that cycle.
REQ-018 On write completion, SHALL advance to the next (m,n) and RUN, or to DONE after the last tile.
REQ-019 done_o SHALL pulse for exactly one cycle in DONE.
REQ-020 busy_o SHALL be 1 in RUN, FLUSH and WRITE.
REQ-021 Per-tile latency SHALL be k_tiles + 2 cycles plus write stall cycles.
REQ-022 Address and read outputs SHALL be 0 when not in RUN.

Reset
REQ-023 Asynchronous assertion of rst_ni SHALL force IDLE, clear all counters and accumulators, and drive every output to 0, including during an operation.
REQ-024 After reset, no residual write or done pulse SHALL occur.

Structure
REQ-025 Package gemm_tile_pkg SHALL hold the state enum and default tile constants.
REQ-026 Sub-module gemm_dot_pe SHALL implement one TileK-wide dot product with load/accumulate, instantiated TileM x TileN times.

Verification
REQ-027 1x1x1 tiles, A = identity, B(k,j) = k+j, unsigned: done_o on cycle 4 after start, with one write to addr 0 and C = B.
REQ-028 Sizes 2x3x2, signed random data (including -128): all 4 C tiles match the golden model, written in order 0,1,2,3.
REQ-029 Hold sram_c_ready_i low for 5 cycles on the first write: we_o, addr and data stay stable; the result is unchanged and total latency grows by 5.
REQ-030 All operands 0xFF: unsigned mode gives C = 4*65025 = 260100; signed mode gives C = 4.
REQ-031 k_tiles = 0: done_o pulses 1 cycle after start with no we_o; start_i while busy is ignored.
REQ-032 Assert rst_ni low mid-RUN: outputs go 0 immediately; a fresh start then produces correct results.

Source files
------------

// File: rtl/gemm_tile_pkg.sv
// Shared definitions for the GEMM tile engine.
//   state_e          : controller states (IDLE, RUN, FLUSH, WRITE, DONE)
//   DEF_TILE_M/N/K   : default PE-grid and dot-product depth
//   DEF_IN_WIDTH     : default operand element width
//   DEF_OUT_WIDTH    : default accumulator element width
package gemm_tile_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_TILE_M    = 4;
    localparam int DEF_TILE_N    = 4;
    localparam int DEF_TILE_K    = 4;
    localparam int DEF_IN_WIDTH  = 8;
    localparam int DEF_OUT_WIDTH = 32;

endpackage

// File: rtl/gemm_dot_pe.sv
// One processing element: a TileK-deep dot product of an A row and a B column,
// either loaded into or added onto a wrapping accumulator.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears acc)
//   en            : a valid operand pair is present this cycle
//   load          : replace acc with the dot product instead of adding
//   signed_mode   : 1 = operands are two's complement, 0 = unsigned
//   a_vec, b_vec  : TileK packed elements, element t at bit t*InDataWidth
//   acc           : accumulated result
module gemm_dot_pe #(
    parameter int InDataWidth  = 8,
    parameter int OutDataWidth = 32,
    parameter int TileK        = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en,
    input  logic                           load,
    input  logic                           signed_mode,
    input  logic [InDataWidth*TileK-1:0]   a_vec,
    input  logic [InDataWidth*TileK-1:0]   b_vec,
    output logic [OutDataWidth-1:0]        acc
);

    logic [OutDataWidth-1:0] prod_ext [TileK];
    logic [OutDataWidth-1:0] dot_sum;

    for (genvar gi = 0; gi < TileK; gi++) begin : g_mul
        logic        [InDataWidth-1:0]   a_el;
        logic        [InDataWidth-1:0]   b_el;
        logic signed [2*InDataWidth-1:0] prod_s;
        logic        [2*InDataWidth-1:0] prod_u;

        assign a_el   = a_vec[gi*InDataWidth +: InDataWidth];
        assign b_el   = b_vec[gi*InDataWidth +: InDataWidth];
        assign prod_s = $signed(a_el) * $signed(b_el);
        assign prod_u = a_el * b_el;
        // Size casts extend according to the operand's signedness.
        assign prod_ext[gi] = signed_mode ? OutDataWidth'(prod_s) : OutDataWidth'(prod_u);
    end

    always_comb begin
        dot_sum = '0;
        for (int k = 0; k < TileK; k++) begin
            dot_sum = dot_sum + prod_ext[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? dot_sum : acc + dot_sum;
        end
    end

endmodule

// File: rtl/gemm_tile_engine.sv
// Tiled matrix-multiply engine: C = A x B over m_tiles x n_tiles output tiles,
// each the sum of k_tiles tile products, computed on a TileM x TileN PE grid.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   start_i, signed_i        : start pulse and operand mode (sampled in IDLE)
//   m/k/n_tiles_i            : problem size in tiles
//   sram_a/b_addr_o, sram_rd_o, sram_a/b_rdata_i : tile reads, data one cycle later
//   sram_c_addr_o, sram_c_wdata_o, sram_c_we_o, sram_c_ready_i : tile write handshake
//   busy_o, done_o           : activity flag and one-cycle completion pulse
module gemm_tile_engine
    import gemm_tile_pkg::*;
#(
    parameter int InDataWidth   = DEF_IN_WIDTH,
    parameter int OutDataWidth  = DEF_OUT_WIDTH,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int TileM         = DEF_TILE_M,
    parameter int TileN         = DEF_TILE_N,
    parameter int TileK         = DEF_TILE_K
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 signed_i,
    input  logic [SizeAddrWidth-1:0]             m_tiles_i,
    input  logic [SizeAddrWidth-1:0]             k_tiles_i,
    input  logic [SizeAddrWidth-1:0]             n_tiles_i,
    output logic [AddrWidth-1:0]                 sram_a_addr_o,
    output logic [AddrWidth-1:0]                 sram_b_addr_o,
    output logic                                 sram_rd_o,
    input  logic [InDataWidth*TileM*TileK-1:0]   sram_a_rdata_i,
    input  logic [InDataWidth*TileK*TileN-1:0]   sram_b_rdata_i,
    output logic [AddrWidth-1:0]                 sram_c_addr_o,
    output logic [OutDataWidth*TileM*TileN-1:0]  sram_c_wdata_o,
    output logic                                 sram_c_we_o,
    input  logic                                 sram_c_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    state_e state_reg, state_next;

    logic [SizeAddrWidth-1:0] m_tiles_reg, k_tiles_reg, n_tiles_reg;
    logic [SizeAddrWidth-1:0] m_cnt_reg, n_cnt_reg, k_cnt_reg;
    logic                     signed_reg;
    // Marks that the read issued last cycle returns data now, and whether it was k = 0.
    logic                     rd_valid_reg;
    logic                     first_reg;

    logic k_last, n_last, m_last, size_zero;
    logic [AddrWidth-1:0] a_addr, b_addr, c_addr;
    logic [OutDataWidth*TileM*TileN-1:0] c_tile;

    assign k_last    = (k_cnt_reg == k_tiles_reg - 1'b1);
    assign n_last    = (n_cnt_reg == n_tiles_reg - 1'b1);
    assign m_last    = (m_cnt_reg == m_tiles_reg - 1'b1);
    assign size_zero = (m_tiles_i == '0) || (k_tiles_i == '0) || (n_tiles_i == '0);

    // Operands are narrowed/widened to AddrWidth first; the result is the same modulo 2^AddrWidth.
    assign a_addr = AddrWidth'(m_cnt_reg) * AddrWidth'(k_tiles_reg) + AddrWidth'(k_cnt_reg);
    assign b_addr = AddrWidth'(k_cnt_reg) * AddrWidth'(n_tiles_reg) + AddrWidth'(n_cnt_reg);
    assign c_addr = AddrWidth'(m_cnt_reg) * AddrWidth'(n_tiles_reg) + AddrWidth'(n_cnt_reg);

    assign sram_a_addr_o  = (state_reg == RUN)   ? a_addr : '0;
    assign sram_b_addr_o  = (state_reg == RUN)   ? b_addr : '0;
    assign sram_c_we_o    = (state_reg == WRITE);
    assign sram_c_addr_o  = (state_reg == WRITE) ? c_addr : '0;
    assign sram_c_wdata_o = (state_reg == WRITE) ? c_tile : '0;

    always_comb begin
        state_next = state_reg;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        sram_rd_o  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = size_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o    = 1'b1;
                sram_rd_o = 1'b1;
                if (k_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy_o     = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy_o = 1'b1;
                if (sram_c_ready_i) begin
                    state_next = (m_last && n_last) ? DONE : RUN;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            m_tiles_reg  <= '0;
            k_tiles_reg  <= '0;
            n_tiles_reg  <= '0;
            m_cnt_reg    <= '0;
            n_cnt_reg    <= '0;
            k_cnt_reg    <= '0;
            signed_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= (state_reg == RUN);
            first_reg    <= (state_reg == RUN) && (k_cnt_reg == '0);
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        m_tiles_reg <= m_tiles_i;
                        k_tiles_reg <= k_tiles_i;
                        n_tiles_reg <= n_tiles_i;
                        signed_reg  <= signed_i;
                        m_cnt_reg   <= '0;
                        n_cnt_reg   <= '0;
                        k_cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    k_cnt_reg <= k_last ? '0 : k_cnt_reg + 1'b1;
                end
                WRITE: begin
                    if (sram_c_ready_i) begin
                        if (n_last) begin
                            n_cnt_reg <= '0;
                            m_cnt_reg <= m_cnt_reg + 1'b1;
                        end else begin
                            n_cnt_reg <= n_cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A rows and B columns are contiguous TileK-element slices of the tiles.
    for (genvar gi = 0; gi < TileM; gi++) begin : g_row
        for (genvar gj = 0; gj < TileN; gj++) begin : g_col
            gemm_dot_pe #(
                .InDataWidth (InDataWidth),
                .OutDataWidth(OutDataWidth),
                .TileK       (TileK)
            ) u_pe (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .en         (rd_valid_reg),
                .load       (first_reg),
                .signed_mode(signed_reg),
                .a_vec      (sram_a_rdata_i[gi*TileK*InDataWidth +: TileK*InDataWidth]),
                .b_vec      (sram_b_rdata_i[gj*TileK*InDataWidth +: TileK*InDataWidth]),
                .acc        (c_tile[(gi*TileN+gj)*OutDataWidth +: OutDataWidth])
            );
        end
    end

endmodule
